// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory bus controller: FSM states, access sizes,
// default ack-wait limit, and the alignment rule used by both the controller and tests.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] SZ_WORD     = 2'b10;
    localparam logic [1:0] SZ_WORD_ALT = 2'b11;

    localparam int TIMEOUT_DEFAULT = 255;

    // Encoding 11 falls into the word rule, so it needs a 4-byte boundary too.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering: byte enables and replicated store data toward the bus,
// lane selection plus sign/zero extension for load data coming back. Purely combinational.
module dmem_byte_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_rep,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        be      = 4'b1111;
        st_rep  = st_data;
        ld_data = ld_word;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << off;
                st_rep  = {4{st_data[7:0]}};
                ld_data = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                be      = 4'b0011 << off;
                st_rep  = {2{st_data[15:0]}};
                ld_data = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory bus controller: issues one registered bus request per load/store,
// stalls the pipeline until ack, optional ack timeout when DMEM_TIMEOUT_EN is defined.
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_hold,
    input  logic        mem_flush,
    output logic        DM_busy,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t      state, state_nxt;
    logic        access, misal, start, abort, abort_now, timeout_hit;
    logic [1:0]  req_size, req_off;
    logic        req_uns;
    logic [1:0]  ln_size, ln_off;
    logic [3:0]  ln_be;
    logic [31:0] ln_wdata, ln_rdata;

    assign access    = mem_read | mem_write;
    assign misal     = misaligned(mem_size, addr[1:0]);
    assign start     = (state == ST_IDLE) && access && !misal && !mem_flush;
    assign abort_now = abort | mem_flush;

    // Lane logic sees live inputs while idle (to build the request) and the
    // captured access while waiting (to steer the returning word).
    assign ln_size = (state == ST_IDLE) ? mem_size : req_size;
    assign ln_off  = (state == ST_IDLE) ? addr[1:0] : req_off;

    dmem_byte_lane u_lane (
        .size        (ln_size),
        .off         (ln_off),
        .is_unsigned (req_uns),
        .st_data     (wdata),
        .ld_word     (bus_rdata),
        .be          (ln_be),
        .st_rep      (ln_wdata),
        .ld_data     (ln_rdata)
    );

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= 8'd0;
        else if (start)
            tmo_cnt <= 8'd0;
        else if (state == ST_REQ && !bus_ack)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Ack on the limit cycle takes priority over the timeout.
    assign timeout_hit = (state == ST_REQ) && !bus_ack && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ: begin
                if (bus_ack)
                    state_nxt = abort_now ? ST_IDLE : ST_DONE;
                else if (timeout_hit)
                    state_nxt = ST_IDLE;
            end
            ST_DONE: if (!mem_hold) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // DM_busy must never look at mem_hold: the hazard unit derives mem_hold from it.
    always_comb begin
        DM_busy  = start || (state == ST_REQ);
        addr_err = (state == ST_IDLE) && access && misal;
        bus_err  = timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_be    <= 4'h0;
            rdata     <= 32'h0;
            abort     <= 1'b0;
            req_size  <= SZ_BYTE;
            req_off   <= 2'b00;
            req_uns   <= 1'b0;
        end else if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= ln_wdata;
            bus_be    <= ln_be;
            abort     <= 1'b0;
            req_size  <= mem_size;
            req_off   <= addr[1:0];
            req_uns   <= mem_unsigned;
        end else if (state == ST_REQ) begin
            if (bus_ack) begin
                bus_req <= 1'b0;
                abort   <= 1'b0;
                if (!bus_we && !abort_now)
                    rdata <= ln_rdata;
            end else if (timeout_hit) begin
                bus_req <= 1'b0;
                abort   <= 1'b0;
            end else if (mem_flush) begin
                abort <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: loads, stores, misalignment, flush abort,
// hold in DONE, size 11, async reset mid-request and the ack-wait behaviour.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        mem_hold = 1'b0, mem_flush = 1'b0;
    logic        dm_busy, addr_err, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int total = 0;
    int bad   = 0;
    int n_tx  = 0;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    dmem_bus_ctrl dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
        .mem_hold(mem_hold), .mem_flush(mem_flush), .DM_busy(dm_busy), .rdata(rdata),
        .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always @(negedge clk) begin
        if (bus_req && !prev_req) n_tx++;
        prev_req = bus_req;
    end

    task automatic set_acc(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
    endtask

    task automatic clr_acc();
        set_acc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'h0 || dm_busy !== 1'b0 ||
            bus_err !== 1'b0 || addr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: req=%b we=%b be=%h busy=%b berr=%b aerr=%b, want all 0",
                     bus_req, bus_we, bus_be, dm_busy, bus_err, addr_err);
        end
        total++;
        if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want 0", bus_addr, bus_wdata, rdata);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        int busy = 0;
        set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        if (dm_busy === 1'b1) busy++;
        total++;
        if (bus_req !== 1'b0) begin
            bad++; $display("FAIL wl_idle_req: got %b want 0", bus_req);
        end
        @(negedge clk);
        if (dm_busy === 1'b1) busy++;
        total++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_be !== 4'hF || bus_we !== 1'b0) begin
            bad++;
            $display("FAIL wl_req: req=%b addr=%h be=%h we=%b want 1/00000100/f/0",
                     bus_req, bus_addr, bus_be, bus_we);
        end
        @(negedge clk);
        if (dm_busy === 1'b1) busy++;
        step();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        if (dm_busy === 1'b1) busy++;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        if (dm_busy === 1'b1) busy++;
        total++;
        if (busy !== 4) begin
            bad++; $display("FAIL wl_busy_cycles: got %0d want 4", busy);
        end
        total++;
        if (rdata !== 32'hDEADBEEF || bus_req !== 1'b0) begin
            bad++; $display("FAIL wl_done: rdata=%h req=%b want deadbeef/0", rdata, bus_req);
        end
        step();
        clr_acc();
    endtask

    task automatic test_sub_word_load();
        logic [31:0] va [3];
        logic [1:0]  vs [3];
        logic        vu [3];
        logic [3:0]  vb [3];
        logic [31:0] ve [3];
        va = '{32'h203, 32'h203, 32'h202};
        vs = '{2'b00, 2'b00, 2'b01};
        vu = '{1'b0, 1'b1, 1'b0};
        vb = '{4'b1000, 4'b1000, 4'b1100};
        ve = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011};
        for (int i = 0; i < 3; i++) begin
            set_acc(1'b1, 1'b0, vs[i], vu[i], va[i], 32'h0);
            @(negedge clk);
            step();
            bus_ack = 1'b1; bus_rdata = 32'h80112233;
            @(negedge clk);
            total++;
            if (bus_be !== vb[i] || bus_addr !== 32'h200) begin
                bad++; $display("FAIL ld%0d_be: be=%b addr=%h want %b/00000200", i, bus_be, bus_addr, vb[i]);
            end
            step();
            bus_ack = 1'b0;
            @(negedge clk);
            total++;
            if (rdata !== ve[i]) begin
                bad++; $display("FAIL ld%0d_rdata: got %h want %h", i, rdata, ve[i]);
            end
            step();
            clr_acc();
        end
    endtask

    task automatic test_store();
        int reqs = 0;
        set_acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000ABCD);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1 || bus_be !== 4'b1100 || bus_wdata !== 32'hABCDABCD ||
            bus_we !== 1'b1 || bus_addr !== 32'h300) begin
            bad++;
            $display("FAIL st_req: req=%b be=%b wd=%h we=%b addr=%h want 1/1100/abcdabcd/1/00000300",
                     bus_req, bus_be, bus_wdata, bus_we, bus_addr);
        end
        step();
        set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h1111);
        bus_ack = 1'b1;
        @(negedge clk);
        total++;
        if (bus_be !== 4'b1100 || bus_wdata !== 32'hABCDABCD || bus_we !== 1'b1 || bus_addr !== 32'h300) begin
            bad++;
            $display("FAIL st_stable: be=%b wd=%h we=%b addr=%h want 1100/abcdabcd/1/00000300",
                     bus_be, bus_wdata, bus_we, bus_addr);
        end
        step();
        bus_ack = 1'b0;
        clr_acc();
        @(negedge clk);
        total++;
        if (rdata !== 32'hFFFF8011) begin
            bad++; $display("FAIL st_rdata_kept: got %h want ffff8011", rdata);
        end
        step();
        set_acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h301, 32'h12345678);
        @(negedge clk);
        total++;
        if (addr_err !== 1'b1 || dm_busy !== 1'b0) begin
            bad++; $display("FAIL mis_word: aerr=%b busy=%b want 1/0", addr_err, dm_busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus_req !== 1'b0) reqs++;
        end
        total++;
        if (reqs !== 0) begin
            bad++; $display("FAIL mis_word_noreq: req cycles %0d want 0", reqs);
        end
        step();
        set_acc(1'b1, 1'b0, 2'b01, 1'b0, 32'h303, 32'h0);
        @(negedge clk);
        total++;
        if (addr_err !== 1'b1 || dm_busy !== 1'b0) begin
            bad++; $display("FAIL mis_half: aerr=%b busy=%b want 1/0", addr_err, dm_busy);
        end
        step();
        clr_acc();
    endtask

    task automatic test_flush_hold();
        int n0;
        set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        @(negedge clk);
        step();
        mem_flush = 1'b1;
        clr_acc();
        @(negedge clk);
        total++;
        if (dm_busy !== 1'b1 || bus_req !== 1'b1) begin
            bad++; $display("FAIL fl_req: busy=%b req=%b want 1/1", dm_busy, bus_req);
        end
        step();
        mem_flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
        step();
        bus_ack = 1'b0;
        n0 = n_tx;
        set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        @(negedge clk);
        total++;
        if (dm_busy !== 1'b1 || bus_req !== 1'b0 || rdata !== 32'hFFFF8011) begin
            bad++;
            $display("FAIL fl_idle: busy=%b req=%b rdata=%h want 1/0/ffff8011", dm_busy, bus_req, rdata);
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        step();
        bus_ack = 1'b0; mem_hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (dm_busy !== 1'b0 || rdata !== 32'hCAFEF00D) begin
                bad++; $display("FAIL hold%0d: busy=%b rdata=%h want 0/cafef00d", i, dm_busy, rdata);
            end
            step();
        end
        mem_hold = 1'b0;
        step();
        clr_acc();
        repeat (3) @(negedge clk);
        total++;
        if (n_tx - n0 !== 1) begin
            bad++; $display("FAIL hold_single_tx: got %0d transactions want 1", n_tx - n0);
        end
    endtask

    task automatic test_size3();
        set_acc(1'b1, 1'b0, 2'b11, 1'b0, 32'h602, 32'h0);
        @(negedge clk);
        total++;
        if (addr_err !== 1'b1 || dm_busy !== 1'b0) begin
            bad++; $display("FAIL sz3_mis: aerr=%b busy=%b want 1/0", addr_err, dm_busy);
        end
        step();
        addr = 32'h600;
        @(negedge clk);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h80000001;
        @(negedge clk);
        total++;
        if (bus_be !== 4'hF) begin
            bad++; $display("FAIL sz3_be: got %b want 1111", bus_be);
        end
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        total++;
        if (rdata !== 32'h80000001) begin
            bad++; $display("FAIL sz3_rdata: got %h want 80000001", rdata);
        end
        step();
        clr_acc();
    endtask

    task automatic test_reset_mid_req();
        set_acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h700, 32'hA5A5A5A5);
        @(negedge clk);
        step();
        clr_acc();
        #1;
        total++;
        if (bus_req !== 1'b1 || bus_wdata !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL rm_pre: req=%b wd=%h want 1/a5a5a5a5", bus_req, bus_wdata);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'h0 || dm_busy !== 1'b0 ||
            bus_addr !== 32'h0 || bus_wdata !== 32'h0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL rm_async: req=%b we=%b be=%h busy=%b addr=%h wd=%h rdata=%h want all 0",
                     bus_req, bus_we, bus_be, dm_busy, bus_addr, bus_wdata, rdata);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_ack_wait();
        int nerr = 0;
        int first = 0;
        logic req_after = 1'b1;
        set_acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (first != 0 && c == first + 1) req_after = bus_req;
            if (bus_err === 1'b1) begin
                nerr++;
                if (first == 0) begin
                    first = c;
                    clr_acc();
                end
            end
        end
`ifdef DMEM_TIMEOUT_EN
        total++;
        if (nerr !== 1 || first !== 255) begin
            bad++; $display("FAIL tmo_pulse: pulses=%0d at cycle %0d want 1 at 255", nerr, first);
        end
        total++;
        if (req_after !== 1'b0) begin
            bad++; $display("FAIL tmo_req_drop: req=%b want 0", req_after);
        end
`else
        total++;
        if (nerr !== 0) begin
            bad++; $display("FAIL wait_no_err: pulses=%0d want 0", nerr);
        end
        total++;
        if (bus_req !== 1'b1 || dm_busy !== 1'b1) begin
            bad++; $display("FAIL wait_still_req: req=%b busy=%b want 1/1", bus_req, dm_busy);
        end
`endif
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0;
        step();
        bus_ack = 1'b0;
        clr_acc();
        step();
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_sub_word_load();
        test_store();
        test_flush_hold();
        test_size3();
        test_reset_mid_req();
        test_ack_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, ack wait limit in REQ (used only with DMEM_TIMEOUT_EN).
REQ-002 SHALL have ports, one clock, reset asynchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  MEM-stage load
- mem_write  in  1  MEM-stage store
- mem_size  in  2  00 byte, 01 half, 10 word
- mem_unsigned  in  1  zero-extend loads
- addr  in  32  byte address
- wdata  in  32  store data, LSB-aligned
- mem_hold  in  1  MEMWB_stall from hazard unit
- mem_flush  in  1  EXMEM_flush from hazard unit
- DM_busy  out  1  stall request to hazard unit
- rdata  out  32  extended load data
- addr_err  out  1  misaligned access, combinational
- bus_err  out  1  one-cycle timeout pulse
- bus_req  out  1  bus request, registered
- bus_we  out  1  bus write
- bus_addr  out  32  word address, [1:0]=0
- bus_wdata  out  32  lane-shifted store data
- bus_be  out  4  byte enables
- bus_ack  in  1  bus completion
- bus_rdata  in  32  bus read word

Function
REQ-003 SHALL implement FSM IDLE, REQ, DONE.
REQ-004 SHALL, in IDLE with (mem_read|mem_write), aligned, !mem_flush: assert DM_busy combinationally same cycle, enter REQ next edge with bus_req=1.
REQ-005 SHALL treat misalignment (half addr[0]=1, word addr[1:0]!=0) as: addr_err=1, no bus_req, DM_busy=0.
REQ-006 SHALL hold bus_req, bus_we, bus_addr, bus_wdata, bus_be stable through REQ until bus_ack.
REQ-007 SHALL keep DM_busy=1 throughout REQ; DM_busy SHALL NOT depend on mem_hold (no combinational loop).
REQ-008 SHALL, on bus_ack in REQ: drop bus_req next edge, register extended load data into rdata, enter DONE.
REQ-009 SHALL, in DONE, drive DM_busy=0; stay in DONE holding rdata while mem_hold=1; go IDLE when mem_hold=0 (no re-issue of a held access).
REQ-010 SHALL set a sticky abort flag if mem_flush is seen in REQ; on ack with abort set go IDLE (not DONE), leave rdata unchanged; store still completes on bus.
REQ-011 SHALL generate bus_be: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; bus_wdata = replicated byte/half.
REQ-012 SHALL extract load lane by addr[1:0], sign-extend unless mem_unsigned; word loads pass through.
REQ-013 SHALL treat mem_size=11 as word.
REQ-014 SHALL ignore new access inputs while in REQ or DONE.

Reset
REQ-015 SHALL on rst: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0, abort=0, timeout counter=0, bus_err=0; rst mid-REQ drops bus_req immediately.

Configuration
REQ-016 SHALL with DMEM_TIMEOUT_EN defined: 8-bit counter cleared on REQ entry, increments each REQ cycle without ack; at TIMEOUT_CYCLES pulse bus_err 1 cycle, drop bus_req, go IDLE, DM_busy=0; ack on that same cycle wins (normal completion).
REQ-017 SHALL without DMEM_TIMEOUT_EN: wait indefinitely in REQ, bus_err tied 0, no counter.

Structure
REQ-018 SHALL place state encodings, mem_size encodings, default TIMEOUT_CYCLES in package dmem_pkg.
REQ-019 SHALL put lane logic (bus_be, wdata replication, load extract/extend) in sub-module dmem_byte_lane.

Verification
REQ-020 Word load addr=0x100, ack after 3 cycles, bus_rdata=0xDEADBEEF -> DM_busy high 4 cycles, rdata=0xDEADBEEF in DONE.
REQ-021 Signed byte load addr=0x203, bus_rdata=0x80112233 -> bus_be=1000, rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-022 Half store addr=0x302, wdata=0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1; word store addr=0x301 -> addr_err=1, bus_req never asserts.
REQ-023 mem_flush during REQ, ack later -> FSM returns IDLE, rdata unchanged; mem_hold=1 in DONE for 2 cycles -> single bus transaction.
REQ-024 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err pulse at 4th REQ cycle, bus_req low next edge; rst asserted mid-REQ -> all outputs reset values asynchronously.
